// File: rtl/i2c_controller_pkg.sv
// Shared definitions for the I2C master sequencer: state encodings and bit-count constants.
package i2c_controller_pkg;

  typedef enum logic [7:0] {
    IDLE       = 8'd0,
    START      = 8'd1,
    ADDRESS    = 8'd2,
    READ_ACK   = 8'd3,
    WRITE_DATA = 8'd4,
    READ_ACK2  = 8'd5,
    READ_DATA  = 8'd6,
    WRITE_ACK2 = 8'd7,
    STOP       = 8'd8
  } i2c_state_t;

  // Bit index loaded at the start of each byte (MSB first).
  localparam logic [3:0] COUNT_RST = 4'd7;

endpackage

// File: rtl/i2c_clk_divider.sv
// Divides the system clock down to the I2C bit clock; i2c_clk toggles every DIVIDE clk cycles.
module i2c_clk_divider #(
  parameter int DIVIDE = 4
) (
  input  logic clk,
  input  logic resetN,
  output logic i2c_clk
);

  localparam logic [7:0] LAST = 8'(DIVIDE - 1);

  logic [7:0] div_cnt_q;
  logic       i2c_clk_q;

  // Count 0..DIVIDE-1, wrap and toggle the bit clock; bit clock idles high out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt_q <= 8'd0;
      i2c_clk_q <= 1'b1;
    end else if (div_cnt_q == LAST) begin
      div_cnt_q <= 8'd0;
      i2c_clk_q <= ~i2c_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
      i2c_clk_q <= i2c_clk_q;
    end
  end

  assign i2c_clk = i2c_clk_q;

endmodule

// File: rtl/i2c_controller.sv
// Master-side I2C transaction sequencer: single-byte write/read with address and data ACK handling.
// The FSM advances on the bit-clock rising edge; SDA/SCL enables are updated on the falling
// edge, alongside the datapath's SDA changes, so bus controls never glitch mid-bit.
module i2c_controller
  import i2c_controller_pkg::*;
#(
  parameter int DIVIDE = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic       rw,
  input  logic       SDA_in,
  output logic       i2c_clk,
  output logic       i2c_scl,
  output logic [7:0] state,
  output logic [3:0] count,
  output logic       i2c_scl_en,
  output logic       i2c_write_en,
  output logic       ready,
  output logic       ack_error
);

  i2c_state_t state_q;
  logic [3:0] count_q;
  logic       ack_error_q;
  logic       scl_en_q;
  logic       write_en_q;

  i2c_clk_divider #(.DIVIDE(DIVIDE)) u_div (
    .clk     (clk),
    .resetN  (resetN),
    .i2c_clk (i2c_clk)
  );

  // Protocol FSM: state, bit index and sticky NACK flag advance on the bit-clock rising edge.
  always_ff @(posedge i2c_clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      ack_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= START;
          else        state_q <= IDLE;
        end
        START: begin
          ack_error_q <= 1'b0;
          count_q     <= COUNT_RST;
          state_q     <= ADDRESS;
        end
        ADDRESS: begin
          if (count_q == 4'd0) state_q <= READ_ACK;
          else                 count_q <= count_q - 4'd1;
        end
        READ_ACK: begin
          if (!SDA_in) begin
            count_q <= COUNT_RST;
            state_q <= rw ? READ_DATA : WRITE_DATA;
          end else begin
            ack_error_q <= 1'b1;
            state_q     <= STOP;
          end
        end
        WRITE_DATA: begin
          if (count_q == 4'd0) state_q <= READ_ACK2;
          else                 count_q <= count_q - 4'd1;
        end
        READ_ACK2: begin
          if (SDA_in) ack_error_q <= 1'b1;
          else        ack_error_q <= ack_error_q;
          state_q <= STOP;
        end
        READ_DATA: begin
          if (count_q == 4'd0) state_q <= WRITE_ACK2;
          else                 count_q <= count_q - 4'd1;
        end
        WRITE_ACK2: state_q <= STOP;
        STOP:       state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // Bus enables decoded from the current state and registered on the bit-clock falling edge.
  always_ff @(negedge i2c_clk or negedge resetN) begin
    if (!resetN) begin
      scl_en_q   <= 1'b0;
      write_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:       begin scl_en_q <= 1'b0; write_en_q <= 1'b0; end
        START:      begin scl_en_q <= 1'b0; write_en_q <= 1'b1; end
        ADDRESS:    begin scl_en_q <= 1'b1; write_en_q <= 1'b1; end
        READ_ACK:   begin scl_en_q <= 1'b1; write_en_q <= 1'b0; end
        WRITE_DATA: begin scl_en_q <= 1'b1; write_en_q <= 1'b1; end
        READ_ACK2:  begin scl_en_q <= 1'b1; write_en_q <= 1'b0; end
        READ_DATA:  begin scl_en_q <= 1'b1; write_en_q <= 1'b0; end
        WRITE_ACK2: begin scl_en_q <= 1'b1; write_en_q <= 1'b1; end
        STOP:       begin scl_en_q <= 1'b0; write_en_q <= 1'b1; end
        default:    begin scl_en_q <= 1'b0; write_en_q <= 1'b0; end
      endcase
    end
  end

  assign state        = state_q;
  assign count        = count_q;
  assign ack_error    = ack_error_q;
  assign i2c_scl_en   = scl_en_q;
  assign i2c_write_en = write_en_q;
  assign i2c_scl      = scl_en_q ? i2c_clk : 1'b1;
  assign ready        = (state_q == IDLE);

endmodule

// File: tb/tb_i2c_controller.sv
// Directed self-checking bench for i2c_controller (DIVIDE=4, clk period 10).
module tb_i2c_controller;
  import i2c_controller_pkg::*;

  logic       clk;
  logic       resetN;
  logic       enable;
  logic       rw;
  logic       SDA_in;
  logic       i2c_clk;
  logic       i2c_scl;
  logic [7:0] state;
  logic [3:0] count;
  logic       i2c_scl_en;
  logic       i2c_write_en;
  logic       ready;
  logic       ack_error;

  int checks;
  int fails;
  int edges;
  longint t0, t1, t2;

  i2c_controller #(.DIVIDE(4)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .enable       (enable),
    .rw           (rw),
    .SDA_in       (SDA_in),
    .i2c_clk      (i2c_clk),
    .i2c_scl      (i2c_scl),
    .state        (state),
    .count        (count),
    .i2c_scl_en   (i2c_scl_en),
    .i2c_write_en (i2c_write_en),
    .ready        (ready),
    .ack_error    (ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit-clock period: state/count after the rising edge, enables after the falling edge.
  task automatic step(input logic [7:0] exp_state, input logic [3:0] exp_count,
                      input logic exp_wen, input logic exp_scl_en);
    @(posedge i2c_clk);
    #1;
    edges++;
    chk("state", state, exp_state);
    chk("count", count, exp_count);
    chk("ready", ready, (exp_state == 8'd0));
    @(negedge i2c_clk);
    #1;
    chk("write_en", i2c_write_en, exp_wen);
    chk("scl_en", i2c_scl_en, exp_scl_en);
    if (exp_scl_en) chk("scl_follows", i2c_scl, i2c_clk);
    else            chk("scl_idle", i2c_scl, 1'b1);
  endtask

  initial begin
    checks = 0; fails = 0; edges = 0;
    resetN = 1'b0; enable = 1'b0; rw = 1'b0; SDA_in = 1'b1;

    // Reset values
    #20;
    chk("rst_state", state, 8'd0);
    chk("rst_count", count, 4'd0);
    chk("rst_i2c_clk", i2c_clk, 1'b1);
    chk("rst_scl_en", i2c_scl_en, 1'b0);
    chk("rst_wen", i2c_write_en, 1'b0);
    chk("rst_ack_error", ack_error, 1'b0);
    chk("rst_scl", i2c_scl, 1'b1);
    #3;
    resetN = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b1);

    // Divider: release at 23, clk posedges 25,35,45,55 -> first fall at 55, then every 40
    @(negedge i2c_clk); t0 = $time;
    chk("div_first_fall", t0, 64'd55);
    chk("div_scl_low", i2c_scl, 1'b1);
    @(posedge i2c_clk); t1 = $time;
    chk("div_half", t1 - t0, 64'd40);
    chk("div_scl_high", i2c_scl, 1'b1);
    @(negedge i2c_clk); t2 = $time;
    chk("div_period", t2 - t0, 64'd80);
    chk("div_idle_state", state, 8'd0);
    #1;

    // Write transaction with ACKs; enable pulse during WRITE_DATA must be ignored
    enable = 1'b1; rw = 1'b0; SDA_in = 1'b0;
    step(START, 4'd0, 1'b1, 1'b0);
    enable = 1'b0;
    edges = 0;
    for (int i = 7; i >= 0; i--) step(ADDRESS, 4'(i), 1'b1, 1'b1);
    step(READ_ACK, 4'd0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) enable = 1'b1;
      if (i == 1) enable = 1'b0;
      step(WRITE_DATA, 4'(i), 1'b1, 1'b1);
    end
    step(READ_ACK2, 4'd0, 1'b0, 1'b1);
    step(STOP, 4'd0, 1'b1, 1'b0);
    chk("wr_ack_error", ack_error, 1'b0);
    step(IDLE, 4'd0, 1'b0, 1'b0);
    chk("wr_latency", edges, 20);
    step(IDLE, 4'd0, 1'b0, 1'b0);

    // Read transaction, then enable held high through STOP for back-to-back
    enable = 1'b1; rw = 1'b1; SDA_in = 1'b0;
    step(START, 4'd0, 1'b1, 1'b0);
    enable = 1'b0;
    edges = 0;
    for (int i = 7; i >= 0; i--) step(ADDRESS, 4'(i), 1'b1, 1'b1);
    step(READ_ACK, 4'd0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(READ_DATA, 4'(i), 1'b0, 1'b1);
    step(WRITE_ACK2, 4'd0, 1'b1, 1'b1);
    enable = 1'b1;
    step(STOP, 4'd0, 1'b1, 1'b0);
    chk("rd_ack_error", ack_error, 1'b0);
    rw = 1'b0; SDA_in = 1'b1;
    step(IDLE, 4'd0, 1'b0, 1'b0);
    chk("rd_latency", edges, 20);

    // Back-to-back start after exactly one IDLE period; this one is NACKed on the address
    step(START, 4'd0, 1'b1, 1'b0);
    enable = 1'b0;
    edges = 0;
    for (int i = 7; i >= 0; i--) step(ADDRESS, 4'(i), 1'b1, 1'b1);
    step(READ_ACK, 4'd0, 1'b0, 1'b1);
    step(STOP, 4'd0, 1'b1, 1'b0);
    chk("nack_ack_error", ack_error, 1'b1);
    step(IDLE, 4'd0, 1'b0, 1'b0);
    chk("nack_latency", edges, 11);
    chk("nack_sticky", ack_error, 1'b1);

    // Next transaction clears ack_error in START; reset it mid-ADDRESS at count 4
    enable = 1'b1; SDA_in = 1'b0;
    step(START, 4'd0, 1'b1, 1'b0);
    enable = 1'b0;
    for (int i = 7; i >= 4; i--) step(ADDRESS, 4'(i), 1'b1, 1'b1);
    chk("start_clears_ack", ack_error, 1'b0);
    chk("pre_abort_clk", i2c_clk, 1'b0);
    resetN = 1'b0;
    #1;
    chk("abort_state", state, 8'd0);
    chk("abort_count", count, 4'd0);
    chk("abort_wen", i2c_write_en, 1'b0);
    chk("abort_scl_en", i2c_scl_en, 1'b0);
    chk("abort_i2c_clk", i2c_clk, 1'b1);
    #22;
    resetN = 1'b1;
    #1;
    chk("abort_ready", ready, 1'b1);
    step(IDLE, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
- Master-side I2C transaction sequencer. It sits directly upstream of the I2C master datapath.
- Divides the system clock into the bit clock and runs the protocol FSM on that clock.
- Drives the datapath's state, bit-count, SCL-enable and SDA-write-enable inputs.
- Supports single-byte write or read transactions: START, 7-bit address plus R/W, ACK, one data byte, ACK/NACK, STOP.

Parameters:
- DIVIDE, 4, system-clock cycles per SCL half-period; legal range 2..255.

Ports:
- clk  input  1  system clock
- resetN  input  1  reset, asynchronous, active-low
- enable  input  1  transaction request; sampled in IDLE
- rw  input  1  0=write, 1=read; held stable by requester from enable until ready returns
- SDA_in  input  1  sampled bus SDA, used for slave ACK
- i2c_clk  output  1  internal bit clock; feeds the datapath's SCL input
- i2c_scl  output  1  SCL pin value: i2c_scl_en ? i2c_clk : 1
- state  output  8  current FSM state, encoded per shared package
- count  output  4  bit index 7..0 in ADDRESS, WRITE_DATA and READ_DATA
- i2c_scl_en  output  1  SCL toggling enable
- i2c_write_en  output  1  master drives SDA when 1; SDA released when 0
- ready  output  1  high only while state==IDLE
- ack_error  output  1  sticky: slave NACKed; cleared on entering START

Behaviour:
- Reset (async, resetN=0) forces:
  - state=IDLE, count=0, i2c_clk=1, i2c_scl_en=0, i2c_write_en=0, ack_error=0, divider counter=0.
  - ready reads 1 once resetN releases.
  - Reset mid-transaction aborts immediately; no STOP is generated.
- Divider:
  - Counter runs on posedge clk, 0..DIVIDE-1.
  - At DIVIDE-1 the counter wraps and i2c_clk toggles.
  - SCL period = 2*DIVIDE clk.
- FSM state and count update on posedge i2c_clk. The datapath updates SDA on negedge, so each bit gets a half-period of setup.
- Transitions (one i2c_clk period per state unless noted):
  - IDLE: enable=1 -> START; otherwise stay.
  - START: ack_error<=0, count<=7 -> ADDRESS.
  - ADDRESS: count>0 -> count--, stay; count==0 -> READ_ACK. Occupies 8 periods.
  - READ_ACK: SDA_in==0 -> count<=7, then READ_DATA if rw=1, WRITE_DATA if rw=0. SDA_in==1 -> ack_error<=1, STOP.
  - WRITE_DATA: 8 periods with count 7..0 -> READ_ACK2.
  - READ_ACK2: SDA_in==1 -> ack_error<=1. Always -> STOP.
  - READ_DATA: 8 periods with count 7..0 -> WRITE_ACK2.
  - WRITE_ACK2 -> STOP.
  - STOP -> IDLE.
  - Undefined encoding -> IDLE.
- Output enables, registered on negedge i2c_clk from the current state (same edge as datapath SDA, so glitch-free):
  - i2c_scl_en = 0 in IDLE, START, STOP; 1 otherwise.
  - i2c_write_en = 1 in START, ADDRESS, WRITE_DATA, WRITE_ACK2, STOP; 0 in IDLE, READ_ACK, READ_DATA, READ_ACK2.
- enable asserted while not IDLE is ignored; no queueing.
- enable held high through STOP starts the next transaction on the first posedge in IDLE (one IDLE period minimum).
- rw is sampled only at READ_ACK exit. The rw captured in the address byte by the datapath must match.
- Latency from IDLE:
  - Write with ACKs: 20 i2c_clk posedges until IDLE again (START 1, ADDR 8, ACK 1, DATA 8, ACK2 1, STOP 1).
  - Read: also 20.
  - Address NACK: 11.

Decomposition:
- Shared package (existing define file) holds:
  - State encodings, 8-bit: IDLE=0, START=1, ADDRESS=2, READ_ACK=3, WRITE_DATA=4, READ_ACK2=5, READ_DATA=6, WRITE_ACK2=7, STOP=8.
  - Bit-count reset constant 7.
- One natural sub-module: i2c_clk_divider (parameter DIVIDE; outputs i2c_clk). It is reused by a future slave-side timing check.
- FSM and enable registers stay in i2c_controller.

Test Plan:
- Reset: resetN=0 mid-ADDRESS (count=4) -> same cycle: state=0, count=0, i2c_write_en=0, i2c_scl_en=0, i2c_clk=1; after release, ready=1.
- Divider: DIVIDE=4, enable=0 -> i2c_clk toggles every 4 clk (period 8); i2c_scl stays 1.
- Write with ACK: enable pulse, rw=0, SDA_in=0 at both ACK states -> states 1,2x8 (count 7..0),3,4x8,5,8,0; ack_error=0; ready after 20 i2c_clk posedges; i2c_write_en=0 exactly during states 3 and 5.
- Read: rw=1, SDA_in=0 at READ_ACK -> states 1,2x8,3,6x8,7,8,0; i2c_write_en=0 during READ_DATA, 1 in WRITE_ACK2.
- Address NACK: SDA_in=1 at READ_ACK -> next state STOP (8), ack_error=1, IDLE after 11 posedges; next enable -> ack_error clears in START.
- Back-to-back: enable held high -> exactly one IDLE period between STOP and the next START; enable pulse during WRITE_DATA ignored.
